axi4_master_simple: RTL and testbench
=====================================

// Module: axi4_master_simple
// PURPOSE
//  Simple-bus to AXI4 master bridge: converts one system-bus read or write request into one
//  single-beat AXI transaction and returns data/ack/err to the requester. Used by PL-side
//  agents that reach AXI slaves (PS HP/GP, PL peripherals) through the RP system bus.
//  One outstanding transaction; response timeout guards against hung slaves.
// PARAMETERS
//  AXI_DW  64          data width (32 or 64)
//  AXI_AW  32          address width
//  AXI_IW  8           ID width
//  AXI_SW  AXI_DW>>3   strobe width
//  AXI_ID  0           constant ID driven on axi_awid_o/axi_wid_o/axi_arid_o
//  TO_W    6           timeout counter width; timeout after 2**TO_W-1 cycles
// PORTS
//  axi_clk_i        in   1       clock
//  axi_rst_i        in   1       reset, synchronous, active-high
//  sys_addr_i       in   AXI_AW  request address, sampled with wen/ren
//  sys_wdata_i      in   AXI_DW  write data, sampled with wen
//  sys_sel_i        in   AXI_SW  byte enables, sampled with wen
//  sys_wen_i        in   1       write request pulse
//  sys_ren_i        in   1       read request pulse
//  sys_rdata_o      out  AXI_DW  read data, valid with sys_ack_o
//  sys_err_o        out  1       error, valid with sys_ack_o
//  sys_ack_o        out  1       one-cycle completion pulse
//  sys_busy_o       out  1       high whenever state != IDLE
//  axi_awid_o/axi_wid_o/axi_arid_o  out  AXI_IW  = AXI_ID
//  axi_awaddr_o/axi_araddr_o        out  AXI_AW  latched sys_addr_i
//  axi_awlen_o/axi_arlen_o          out  4       const 0
//  axi_awsize_o/axi_arsize_o        out  3       const log2(AXI_SW)
//  axi_awburst_o/axi_arburst_o      out  2       const 2'b01 INCR
//  axi_awlock_o/axi_arlock_o 2, axi_awcache_o/axi_arcache_o 4, axi_awprot_o/axi_arprot_o 3  out  const 0
//  axi_awvalid_o/axi_awready_i, axi_wvalid_o/axi_wready_i, axi_arvalid_o/axi_arready_i  1  handshakes
//  axi_wdata_o  out AXI_DW, axi_wstrb_o  out AXI_SW (latched), axi_wlast_o  out 1 (= axi_wvalid_o)
//  axi_bid_i/axi_rid_i  in AXI_IW ignored; axi_bresp_i/axi_rresp_i  in 2; axi_rdata_i  in AXI_DW
//  axi_bvalid_i, axi_rvalid_i, axi_rlast_i  in 1; axi_bready_o, axi_rready_o  out 1
// BEHAVIOUR
//  - Reset: state IDLE; all valid/ready outputs, sys_ack_o, sys_err_o, sys_busy_o, orphan = 0;
//    sys_rdata_o, latched addr/data/strb = 0. Reset mid-transaction abandons it; no drain.
//  - FSM IDLE -> WR_REQ | RD_REQ -> WR_RESP | RD_RESP -> IDLE. All AXI outputs registered.
//  - IDLE: sys_wen_i latches addr/wdata/sel, -> WR_REQ; else sys_ren_i latches addr, -> RD_REQ.
//    wen and ren together: write wins, read dropped. Any wen/ren outside IDLE ignored.
//  - WR_REQ: awvalid and wvalid both set on entry; each drops independently after its own
//    handshake (awvalid&awready, wvalid&wready; order free). Both done -> WR_RESP.
//  - WR_RESP: bready=1; on bvalid: bready=0, ack pulse next cycle, err = (bresp != 2'b00), -> IDLE.
//  - RD_REQ: arvalid=1 until arready -> RD_RESP. RD_RESP: rready=1; on rvalid: latch rdata,
//    err = (rresp != 2'b00) | !rlast, ack next cycle, -> IDLE.
//  - Latency with always-ready slave: request cycle N, AW/W/AR handshake N+1, response at
//    N+2 earliest, sys_ack_o at N+3.
//  - Valids never drop before handshake; address/data/strb stable while valid.
//  - Timeout: counter cleared when leaving IDLE, +1 per non-IDLE cycle, saturates. On reaching
//    2**TO_W-1 with orphan=0: sys_ack_o=1, sys_err_o=1, sys_rdata_o=0, orphan set. FSM still
//    completes the AXI transaction normally; completion with orphan=1 gives no ack; orphan
//    cleared on return to IDLE. sys_busy_o stays high until then.
//  - sys_ack_o exactly one per accepted request; never two in consecutive cycles.
// TESTING
//  - Write, slave always ready, bresp=00: wen@N addr=0x40000010 data=0x1234 sel=0xFF ->
//    awvalid/wvalid @N+1, bready @N+2, ack@N+3, err=0.
//  - Read: AR ready after 3 cycles, rdata=0xDEADBEEF, rresp=00, rlast=1 -> arvalid held 3
//    cycles, ack with rdata=0xDEADBEEF, err=0.
//  - W accepted 5 cycles before AW; bresp=2'b10 -> awvalid held, wvalid dropped after own
//    handshake, ack with err=1.
//  - wen and ren same IDLE cycle, then ren while busy -> only one write issued, no AR, one ack.
//  - Slave silent, TO_W=6 -> ack+err at 63 cycles; late bvalid@100 -> no second ack, busy low after.
//  - axi_rst_i mid RD_RESP -> next cycle all valid/ready/ack/busy low, state IDLE.

Source files
------------

// File: rtl/axi4_master_simple_if.sv
// AXI4 bus bundle used between the simple-bus bridge and an AXI slave.
// Signal names keep the direction suffix as seen from the master side.
interface axi4_master_simple_if #(
  parameter int AXI_DW = 64,
  parameter int AXI_AW = 32,
  parameter int AXI_IW = 8,
  parameter int AXI_SW = AXI_DW >> 3
);

  // write address channel
  logic [AXI_IW-1:0] axi_awid_o;
  logic [AXI_AW-1:0] axi_awaddr_o;
  logic [3:0]        axi_awlen_o;
  logic [2:0]        axi_awsize_o;
  logic [1:0]        axi_awburst_o;
  logic [1:0]        axi_awlock_o;
  logic [3:0]        axi_awcache_o;
  logic [2:0]        axi_awprot_o;
  logic              axi_awvalid_o;
  logic              axi_awready_i;

  // write data channel
  logic [AXI_IW-1:0] axi_wid_o;
  logic [AXI_DW-1:0] axi_wdata_o;
  logic [AXI_SW-1:0] axi_wstrb_o;
  logic              axi_wlast_o;
  logic              axi_wvalid_o;
  logic              axi_wready_i;

  // write response channel
  logic [AXI_IW-1:0] axi_bid_i;
  logic [1:0]        axi_bresp_i;
  logic              axi_bvalid_i;
  logic              axi_bready_o;

  // read address channel
  logic [AXI_IW-1:0] axi_arid_o;
  logic [AXI_AW-1:0] axi_araddr_o;
  logic [3:0]        axi_arlen_o;
  logic [2:0]        axi_arsize_o;
  logic [1:0]        axi_arburst_o;
  logic [1:0]        axi_arlock_o;
  logic [3:0]        axi_arcache_o;
  logic [2:0]        axi_arprot_o;
  logic              axi_arvalid_o;
  logic              axi_arready_i;

  // read data channel
  logic [AXI_IW-1:0] axi_rid_i;
  logic [AXI_DW-1:0] axi_rdata_i;
  logic [1:0]        axi_rresp_i;
  logic              axi_rlast_i;
  logic              axi_rvalid_i;
  logic              axi_rready_o;

  modport master (
    output axi_awid_o, axi_awaddr_o, axi_awlen_o, axi_awsize_o, axi_awburst_o,
           axi_awlock_o, axi_awcache_o, axi_awprot_o, axi_awvalid_o,
    input  axi_awready_i,
    output axi_wid_o, axi_wdata_o, axi_wstrb_o, axi_wlast_o, axi_wvalid_o,
    input  axi_wready_i,
    input  axi_bid_i, axi_bresp_i, axi_bvalid_i,
    output axi_bready_o,
    output axi_arid_o, axi_araddr_o, axi_arlen_o, axi_arsize_o, axi_arburst_o,
           axi_arlock_o, axi_arcache_o, axi_arprot_o, axi_arvalid_o,
    input  axi_arready_i,
    input  axi_rid_i, axi_rdata_i, axi_rresp_i, axi_rlast_i, axi_rvalid_i,
    output axi_rready_o
  );

  modport slave (
    input  axi_awid_o, axi_awaddr_o, axi_awlen_o, axi_awsize_o, axi_awburst_o,
           axi_awlock_o, axi_awcache_o, axi_awprot_o, axi_awvalid_o,
    output axi_awready_i,
    input  axi_wid_o, axi_wdata_o, axi_wstrb_o, axi_wlast_o, axi_wvalid_o,
    output axi_wready_i,
    output axi_bid_i, axi_bresp_i, axi_bvalid_i,
    input  axi_bready_o,
    input  axi_arid_o, axi_araddr_o, axi_arlen_o, axi_arsize_o, axi_arburst_o,
           axi_arlock_o, axi_arcache_o, axi_arprot_o, axi_arvalid_o,
    output axi_arready_i,
    output axi_rid_i, axi_rdata_i, axi_rresp_i, axi_rlast_i, axi_rvalid_i,
    input  axi_rready_o
  );

endinterface

// File: rtl/axi4_master_simple.sv
// Simple-bus to AXI4 master bridge: one system-bus read or write becomes one
// single-beat AXI transaction. One transaction outstanding at a time; a
// saturating timeout answers the requester with an error if the slave hangs,
// while the AXI side is still allowed to finish on its own.
module axi4_master_simple #(
  parameter int                AXI_DW = 64,
  parameter int                AXI_AW = 32,
  parameter int                AXI_IW = 8,
  parameter int                AXI_SW = AXI_DW >> 3,
  parameter logic [AXI_IW-1:0] AXI_ID = {AXI_IW{1'b0}},
  parameter int                TO_W   = 6
) (
  input  logic              axi_clk_i,
  input  logic              axi_rst_i,
  input  logic [AXI_AW-1:0] sys_addr_i,
  input  logic [AXI_DW-1:0] sys_wdata_i,
  input  logic [AXI_SW-1:0] sys_sel_i,
  input  logic              sys_wen_i,
  input  logic              sys_ren_i,
  output logic [AXI_DW-1:0] sys_rdata_o,
  output logic              sys_err_o,
  output logic              sys_ack_o,
  output logic              sys_busy_o,
  axi4_master_simple_if.master axi
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_REQ  = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_RESP = 3'd4
  } state_e;

  localparam logic [2:0]      AXI_SIZE = 3'($clog2(AXI_SW));
  localparam logic [TO_W-1:0] TO_MAX   = {TO_W{1'b1}};
  localparam logic [TO_W-1:0] TO_PRE   = {{(TO_W-1){1'b1}}, 1'b0};
  localparam logic [TO_W-1:0] TO_ONE   = {{(TO_W-1){1'b0}}, 1'b1};

  state_e            state_q,   state_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q,  wvalid_d;
  logic              arvalid_q, arvalid_d;
  logic              bready_q,  bready_d;
  logic              rready_q,  rready_d;
  logic [AXI_AW-1:0] addr_q,    addr_d;
  logic [AXI_DW-1:0] wdata_q,   wdata_d;
  logic [AXI_SW-1:0] strb_q,    strb_d;
  logic [AXI_DW-1:0] rdata_q,   rdata_d;
  logic              ack_q,     ack_d;
  logic              err_q,     err_d;
  logic              busy_q,    busy_d;
  logic              orphan_q,  orphan_d;
  logic [TO_W-1:0]   cnt_q,     cnt_d;

  // completion results from the AXI side, before merging with the timeout
  logic              cmp_ack_s;
  logic              cmp_err_s;
  logic [AXI_DW-1:0] rd_lat_s;
  logic              to_fire_s;

  // IDs are fixed, so returned IDs carry no information
  logic unused_ids_s;
  assign unused_ids_s = ^{axi.axi_bid_i, axi.axi_rid_i};

  // constant AXI attributes: single-beat INCR, full-width, normal access
  assign axi.axi_awid_o    = AXI_ID;
  assign axi.axi_wid_o     = AXI_ID;
  assign axi.axi_arid_o    = AXI_ID;
  assign axi.axi_awlen_o   = 4'd0;
  assign axi.axi_arlen_o   = 4'd0;
  assign axi.axi_awsize_o  = AXI_SIZE;
  assign axi.axi_arsize_o  = AXI_SIZE;
  assign axi.axi_awburst_o = 2'b01;
  assign axi.axi_arburst_o = 2'b01;
  assign axi.axi_awlock_o  = 2'b00;
  assign axi.axi_arlock_o  = 2'b00;
  assign axi.axi_awcache_o = 4'b0000;
  assign axi.axi_arcache_o = 4'b0000;
  assign axi.axi_awprot_o  = 3'b000;
  assign axi.axi_arprot_o  = 3'b000;

  // everything below is driven straight from registers
  assign axi.axi_awaddr_o  = addr_q;
  assign axi.axi_araddr_o  = addr_q;
  assign axi.axi_awvalid_o = awvalid_q;
  assign axi.axi_wdata_o   = wdata_q;
  assign axi.axi_wstrb_o   = strb_q;
  assign axi.axi_wvalid_o  = wvalid_q;
  assign axi.axi_wlast_o   = wvalid_q;
  assign axi.axi_arvalid_o = arvalid_q;
  assign axi.axi_bready_o  = bready_q;
  assign axi.axi_rready_o  = rready_q;

  assign sys_rdata_o = rdata_q;
  assign sys_err_o   = err_q;
  assign sys_ack_o   = ack_q;
  assign sys_busy_o  = busy_q;

  // next-state and registered-output logic for the transaction FSM and timeout
  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    bready_d  = bready_q;
    rready_d  = rready_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    cmp_ack_s = 1'b0;
    cmp_err_s = 1'b0;
    rd_lat_s  = rdata_q;

    case (state_q)
      S_IDLE: begin
        // a write wins over a simultaneous read; the read is dropped
        if (sys_wen_i) begin
          addr_d    = sys_addr_i;
          wdata_d   = sys_wdata_i;
          strb_d    = sys_sel_i;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = S_WR_REQ;
        end else if (sys_ren_i) begin
          addr_d    = sys_addr_i;
          arvalid_d = 1'b1;
          state_d   = S_RD_REQ;
        end else begin
          state_d   = S_IDLE;
        end
      end

      S_WR_REQ: begin
        // AW and W complete independently, in either order
        if (awvalid_q && axi.axi_awready_i) begin
          awvalid_d = 1'b0;
        end else begin
          awvalid_d = awvalid_q;
        end
        if (wvalid_q && axi.axi_wready_i) begin
          wvalid_d = 1'b0;
        end else begin
          wvalid_d = wvalid_q;
        end
        if ((!awvalid_q || axi.axi_awready_i) && (!wvalid_q || axi.axi_wready_i)) begin
          bready_d = 1'b1;
          state_d  = S_WR_RESP;
        end else begin
          state_d  = S_WR_REQ;
        end
      end

      S_WR_RESP: begin
        if (axi.axi_bvalid_i) begin
          bready_d  = 1'b0;
          state_d   = S_IDLE;
          cmp_ack_s = !orphan_q;
          cmp_err_s = !orphan_q && (axi.axi_bresp_i != 2'b00);
        end else begin
          state_d   = S_WR_RESP;
        end
      end

      S_RD_REQ: begin
        if (axi.axi_arready_i) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_RESP;
        end else begin
          state_d   = S_RD_REQ;
        end
      end

      S_RD_RESP: begin
        // a read that already timed out keeps the zero data it reported
        if (axi.axi_rvalid_i) begin
          rready_d  = 1'b0;
          state_d   = S_IDLE;
          cmp_ack_s = !orphan_q;
          cmp_err_s = !orphan_q && ((axi.axi_rresp_i != 2'b00) || !axi.axi_rlast_i);
          if (!orphan_q) begin
            rd_lat_s = axi.axi_rdata_i;
          end else begin
            rd_lat_s = rdata_q;
          end
        end else begin
          state_d   = S_RD_RESP;
        end
      end

      default: begin
        state_d   = S_IDLE;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        arvalid_d = 1'b0;
        bready_d  = 1'b0;
        rready_d  = 1'b0;
      end
    endcase

    // timeout counter: zero in IDLE, counts busy cycles, saturates
    if (state_q == S_IDLE) begin
      cnt_d = {TO_W{1'b0}};
    end else if (cnt_q == TO_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + TO_ONE;
    end

    // fires on the cycle the counter reaches its maximum, once per request,
    // and never together with a normal completion
    to_fire_s = (state_q != S_IDLE) && (state_d != S_IDLE) &&
                (cnt_q == TO_PRE) && !orphan_q;

    ack_d   = cmp_ack_s || to_fire_s;
    err_d   = cmp_err_s || to_fire_s;
    rdata_d = to_fire_s ? {AXI_DW{1'b0}} : rd_lat_s;

    if (state_d == S_IDLE) begin
      orphan_d = 1'b0;
    end else if (to_fire_s) begin
      orphan_d = 1'b1;
    end else begin
      orphan_d = orphan_q;
    end

    busy_d = (state_d != S_IDLE);
  end

  // state and output registers with synchronous reset; reset abandons any transfer
  always_ff @(posedge axi_clk_i) begin
    if (axi_rst_i) begin
      state_q   <= S_IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      rready_q  <= 1'b0;
      addr_q    <= {AXI_AW{1'b0}};
      wdata_q   <= {AXI_DW{1'b0}};
      strb_q    <= {AXI_SW{1'b0}};
      rdata_q   <= {AXI_DW{1'b0}};
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      orphan_q  <= 1'b0;
      cnt_q     <= {TO_W{1'b0}};
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      bready_q  <= bready_d;
      rready_q  <= rready_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      rdata_q   <= rdata_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      orphan_q  <= orphan_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_axi4_master_simple.sv
// Self-checking bench for axi4_master_simple: a configurable AXI slave model,
// an expected-response queue and one task per scenario.
module tb_axi4_master_simple;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] sys_addr = 32'h0;
  logic [63:0] sys_wdata = 64'h0;
  logic [7:0]  sys_sel = 8'h0;
  logic        sys_wen = 1'b0;
  logic        sys_ren = 1'b0;
  logic [63:0] sys_rdata;
  logic        sys_err, sys_ack, sys_busy;

  axi4_master_simple_if #(.AXI_DW(64), .AXI_AW(32), .AXI_IW(8), .AXI_SW(8)) axi_if ();

  axi4_master_simple #(.AXI_DW(64), .AXI_AW(32), .AXI_IW(8), .AXI_SW(8),
                       .AXI_ID(8'h00), .TO_W(6)) dut (
    .axi_clk_i(clk), .axi_rst_i(rst),
    .sys_addr_i(sys_addr), .sys_wdata_i(sys_wdata), .sys_sel_i(sys_sel),
    .sys_wen_i(sys_wen), .sys_ren_i(sys_ren),
    .sys_rdata_o(sys_rdata), .sys_err_o(sys_err), .sys_ack_o(sys_ack), .sys_busy_o(sys_busy),
    .axi(axi_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vec_cnt = 0;
  int err_cnt = 0;

  typedef struct { logic err; logic [63:0] rdata; logic chk; } exp_t;
  exp_t exp_q[$];

  // slave configuration
  int aw_dly, w_dly, ar_dly, b_dly, r_dly;
  logic [1:0]  bresp_cfg, rresp_cfg;
  logic        rlast_cfg;
  logic [63:0] rdata_cfg;
  int aw_c, w_c, ar_c, b_c, r_c;

  // slave model: ready/valid recomputed just after every clock edge
  initial begin
    axi_if.axi_awready_i = 1'b0; axi_if.axi_wready_i = 1'b0; axi_if.axi_arready_i = 1'b0;
    axi_if.axi_bvalid_i = 1'b0; axi_if.axi_rvalid_i = 1'b0;
    axi_if.axi_bid_i = 8'h00; axi_if.axi_rid_i = 8'h00;
    axi_if.axi_bresp_i = 2'b00; axi_if.axi_rresp_i = 2'b00;
    axi_if.axi_rlast_i = 1'b0; axi_if.axi_rdata_i = 64'h0;
    aw_c = 0; w_c = 0; ar_c = 0; b_c = 0; r_c = 0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        aw_c = 0; w_c = 0; ar_c = 0; b_c = 0; r_c = 0;
        axi_if.axi_awready_i = 1'b0; axi_if.axi_wready_i = 1'b0; axi_if.axi_arready_i = 1'b0;
        axi_if.axi_bvalid_i = 1'b0; axi_if.axi_rvalid_i = 1'b0;
      end else begin
        if (axi_if.axi_awvalid_o) begin aw_c++; axi_if.axi_awready_i = (aw_c > aw_dly); end
        else begin aw_c = 0; axi_if.axi_awready_i = 1'b0; end
        if (axi_if.axi_wvalid_o) begin w_c++; axi_if.axi_wready_i = (w_c > w_dly); end
        else begin w_c = 0; axi_if.axi_wready_i = 1'b0; end
        if (axi_if.axi_arvalid_o) begin ar_c++; axi_if.axi_arready_i = (ar_c > ar_dly); end
        else begin ar_c = 0; axi_if.axi_arready_i = 1'b0; end
        if (axi_if.axi_bready_o) begin b_c++; axi_if.axi_bvalid_i = (b_c > b_dly); end
        else begin b_c = 0; axi_if.axi_bvalid_i = 1'b0; end
        axi_if.axi_bresp_i = bresp_cfg;
        if (axi_if.axi_rready_o) begin r_c++; axi_if.axi_rvalid_i = (r_c > r_dly); end
        else begin r_c = 0; axi_if.axi_rvalid_i = 1'b0; end
        axi_if.axi_rresp_i = rresp_cfg;
        axi_if.axi_rlast_i = rlast_cfg;
        axi_if.axi_rdata_i = rdata_cfg;
      end
    end
  end

  // observation results
  int first_aw, first_w, first_ar, first_b, first_r, first_bv, first_busy, first_ack, busy_low;
  int n_aw, n_w, n_ar, n_ack;
  logic        ack_err, dbl_ack, stab_bad, wlast_bad, done, prev_ack;
  logic [63:0] ack_rdata, w_data_seen;
  logic [31:0] aw_addr_seen, ar_addr_seen;
  logic [7:0]  w_strb_seen;

  task automatic slave_cfg(input int awd, input int wd, input int ard, input int bd, input int rd);
    aw_dly = awd; w_dly = wd; ar_dly = ard; b_dly = bd; r_dly = rd;
    bresp_cfg = 2'b00; rresp_cfg = 2'b00; rlast_cfg = 1'b1; rdata_cfg = 64'h0;
  endtask

  // watch the bus at negedges until the request has been answered and busy has dropped
  task automatic observe(input int max_cyc, input int ren_at);
    first_aw = -1; first_w = -1; first_ar = -1; first_b = -1; first_r = -1; first_bv = -1;
    first_busy = -1; first_ack = -1; busy_low = -1;
    n_aw = 0; n_w = 0; n_ar = 0; n_ack = 0;
    ack_err = 1'bx; ack_rdata = 64'hx; dbl_ack = 1'b0; stab_bad = 1'b0; wlast_bad = 1'b0;
    done = 1'b0; prev_ack = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      sys_wen = 1'b0;
      sys_ren = (i == ren_at);
      if (axi_if.axi_awvalid_o) begin
        if (first_aw < 0) begin first_aw = cyc; aw_addr_seen = axi_if.axi_awaddr_o; end
        else if (axi_if.axi_awaddr_o !== aw_addr_seen) stab_bad = 1'b1;
        n_aw++;
      end
      if (axi_if.axi_wvalid_o) begin
        if (first_w < 0) begin first_w = cyc; w_data_seen = axi_if.axi_wdata_o; w_strb_seen = axi_if.axi_wstrb_o; end
        else if (axi_if.axi_wdata_o !== w_data_seen || axi_if.axi_wstrb_o !== w_strb_seen) stab_bad = 1'b1;
        n_w++;
      end
      if (axi_if.axi_wlast_o !== axi_if.axi_wvalid_o) wlast_bad = 1'b1;
      if (axi_if.axi_arvalid_o) begin
        if (first_ar < 0) begin first_ar = cyc; ar_addr_seen = axi_if.axi_araddr_o; end
        else if (axi_if.axi_araddr_o !== ar_addr_seen) stab_bad = 1'b1;
        n_ar++;
      end
      if (axi_if.axi_bready_o && first_b < 0) first_b = cyc;
      if (axi_if.axi_rready_o && first_r < 0) first_r = cyc;
      if (axi_if.axi_bvalid_i && first_bv < 0) first_bv = cyc;
      if (sys_busy && first_busy < 0) first_busy = cyc;
      if (sys_ack) begin
        n_ack++;
        if (first_ack < 0) begin first_ack = cyc; ack_err = sys_err; ack_rdata = sys_rdata; end
        if (prev_ack) dbl_ack = 1'b1;
      end
      prev_ack = sys_ack;
      if (n_ack > 0 && !sys_busy) begin busy_low = cyc; done = 1'b1; break; end
    end
    sys_ren = 1'b0;
  endtask

  task automatic test_reset();
    vec_cnt++; if ({sys_ack, sys_err, sys_busy} !== 3'b000) begin err_cnt++; $display("FAIL rst_sys: got %b expected 000", {sys_ack, sys_err, sys_busy}); end
    vec_cnt++; if (sys_rdata !== 64'h0) begin err_cnt++; $display("FAIL rst_rdata: got %h expected 0", sys_rdata); end
    vec_cnt++; if ({axi_if.axi_awvalid_o, axi_if.axi_wvalid_o, axi_if.axi_arvalid_o, axi_if.axi_bready_o, axi_if.axi_rready_o} !== 5'b00000) begin err_cnt++; $display("FAIL rst_handshake: got %b expected 00000", {axi_if.axi_awvalid_o, axi_if.axi_wvalid_o, axi_if.axi_arvalid_o, axi_if.axi_bready_o, axi_if.axi_rready_o}); end
    vec_cnt++; if ({axi_if.axi_awaddr_o, axi_if.axi_wstrb_o} !== 40'h0) begin err_cnt++; $display("FAIL rst_latched: got %h expected 0", {axi_if.axi_awaddr_o, axi_if.axi_wstrb_o}); end
    vec_cnt++; if ({axi_if.axi_awlen_o, axi_if.axi_awsize_o, axi_if.axi_awburst_o} !== {4'd0, 3'd3, 2'b01}) begin err_cnt++; $display("FAIL rst_aw_attr: got %h expected %h", {axi_if.axi_awlen_o, axi_if.axi_awsize_o, axi_if.axi_awburst_o}, {4'd0, 3'd3, 2'b01}); end
    vec_cnt++; if ({axi_if.axi_arlen_o, axi_if.axi_arsize_o, axi_if.axi_arburst_o} !== {4'd0, 3'd3, 2'b01}) begin err_cnt++; $display("FAIL rst_ar_attr: got %h expected %h", {axi_if.axi_arlen_o, axi_if.axi_arsize_o, axi_if.axi_arburst_o}, {4'd0, 3'd3, 2'b01}); end
  endtask

  task automatic test_write();
    int n; exp_t e;
    slave_cfg(0, 0, 0, 0, 0);
    @(negedge clk);
    sys_wen = 1'b1; sys_addr = 32'h4000_0010; sys_wdata = 64'h1234; sys_sel = 8'hFF;
    n = cyc; e.err = 1'b0; e.rdata = 64'h0; e.chk = 1'b0; exp_q.push_back(e);
    observe(30, -1);
    vec_cnt++; if (!done) begin err_cnt++; $display("FAIL wr_done: got %0d expected 1", done); end
    vec_cnt++; if (first_aw !== n + 1 || first_w !== n + 1) begin err_cnt++; $display("FAIL wr_awv_cyc: got %0d/%0d expected %0d", first_aw, first_w, n + 1); end
    vec_cnt++; if (first_b !== n + 2) begin err_cnt++; $display("FAIL wr_bready_cyc: got %0d expected %0d", first_b, n + 2); end
    vec_cnt++; if (first_ack !== n + 3) begin err_cnt++; $display("FAIL wr_ack_cyc: got %0d expected %0d", first_ack, n + 3); end
    vec_cnt++; if ({aw_addr_seen, w_data_seen, w_strb_seen} !== {32'h4000_0010, 64'h1234, 8'hFF}) begin err_cnt++; $display("FAIL wr_payload: got %h expected %h", {aw_addr_seen, w_data_seen, w_strb_seen}, {32'h4000_0010, 64'h1234, 8'hFF}); end
    vec_cnt++; if ({wlast_bad, stab_bad, dbl_ack} !== 3'b000 || n_ack !== 1 || first_ar !== -1) begin err_cnt++; $display("FAIL wr_misc: got wl/st/dbl %b acks %0d ar %0d expected 000 1 -1", {wlast_bad, stab_bad, dbl_ack}, n_ack, first_ar); end
    e = exp_q.pop_front();
    vec_cnt++; if (ack_err !== e.err) begin err_cnt++; $display("FAIL wr_err: got %b expected %b", ack_err, e.err); end
  endtask

  task automatic test_read();
    exp_t e;
    slave_cfg(0, 0, 2, 0, 0);
    rdata_cfg = 64'hDEAD_BEEF;
    @(negedge clk);
    sys_ren = 1'b1; sys_addr = 32'h8000_0100;
    e.err = 1'b0; e.rdata = 64'hDEAD_BEEF; e.chk = 1'b1; exp_q.push_back(e);
    observe(30, 0);
    vec_cnt++; if (!done || n_ack !== 1) begin err_cnt++; $display("FAIL rd_done: got done %0d acks %0d expected 1 1", done, n_ack); end
    vec_cnt++; if (n_ar !== 3) begin err_cnt++; $display("FAIL rd_arvalid_len: got %0d expected 3", n_ar); end
    vec_cnt++; if (ar_addr_seen !== 32'h8000_0100 || stab_bad !== 1'b0) begin err_cnt++; $display("FAIL rd_araddr: got %h stab %b expected 80000100 0", ar_addr_seen, stab_bad); end
    e = exp_q.pop_front();
    vec_cnt++; if (ack_err !== e.err) begin err_cnt++; $display("FAIL rd_err: got %b expected %b", ack_err, e.err); end
    vec_cnt++; if (ack_rdata !== e.rdata) begin err_cnt++; $display("FAIL rd_data: got %h expected %h", ack_rdata, e.rdata); end
  endtask

  task automatic test_w_before_aw();
    exp_t e;
    slave_cfg(5, 0, 0, 0, 0);
    bresp_cfg = 2'b10;
    @(negedge clk);
    sys_wen = 1'b1; sys_addr = 32'h4000_0020; sys_wdata = 64'hCAFE_0000_5555_AAAA; sys_sel = 8'h0F;
    e.err = 1'b1; e.rdata = 64'h0; e.chk = 1'b0; exp_q.push_back(e);
    observe(40, -1);
    vec_cnt++; if (n_w !== 1 || n_aw !== 6) begin err_cnt++; $display("FAIL wfirst_valid_len: got w %0d aw %0d expected 1 6", n_w, n_aw); end
    vec_cnt++; if (stab_bad !== 1'b0 || n_ack !== 1 || !done) begin err_cnt++; $display("FAIL wfirst_misc: got stab %b acks %0d done %b expected 0 1 1", stab_bad, n_ack, done); end
    e = exp_q.pop_front();
    vec_cnt++; if (ack_err !== e.err) begin err_cnt++; $display("FAIL wfirst_err: got %b expected %b", ack_err, e.err); end
  endtask

  task automatic test_wen_ren();
    exp_t e; int acks1, ar1, aw1;
    slave_cfg(0, 0, 0, 0, 0);
    @(negedge clk);
    sys_wen = 1'b1; sys_ren = 1'b1; sys_addr = 32'h4000_0030; sys_wdata = 64'h77; sys_sel = 8'h01;
    e.err = 1'b0; e.rdata = 64'h0; e.chk = 1'b0; exp_q.push_back(e);
    observe(30, 0);
    acks1 = n_ack; ar1 = first_ar; aw1 = n_aw;
    e = exp_q.pop_front();
    vec_cnt++; if (ack_err !== e.err) begin err_cnt++; $display("FAIL wr_rd_err: got %b expected %b", ack_err, e.err); end
    observe(8, -1);
    vec_cnt++; if (acks1 !== 1 || n_ack !== 0) begin err_cnt++; $display("FAIL wr_rd_acks: got %0d then %0d expected 1 then 0", acks1, n_ack); end
    vec_cnt++; if (ar1 !== -1 || first_ar !== -1 || aw1 !== 1 || first_aw !== -1) begin err_cnt++; $display("FAIL wr_rd_issue: got ar %0d/%0d aw %0d/%0d expected -1/-1 1/-1", ar1, first_ar, aw1, first_aw); end
  endtask

  task automatic test_read_err();
    logic [1:0] rr [4];
    logic       rl [4];
    logic       ee [4];
    exp_t e;
    rr = '{2'b00, 2'b11, 2'b01, 2'b00};
    rl = '{1'b0, 1'b1, 1'b1, 1'b1};
    ee = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 4; k++) begin
      slave_cfg(0, 0, 0, k, 0);
      rresp_cfg = rr[k]; rlast_cfg = rl[k]; rdata_cfg = 64'hA5A5_0000_0000_0010 + 64'(k);
      @(negedge clk);
      sys_ren = 1'b1; sys_addr = 32'h9000_0000 + 32'(k * 8);
      e.err = ee[k]; e.rdata = rdata_cfg; e.chk = 1'b1; exp_q.push_back(e);
      observe(30, 0);
      e = exp_q.pop_front();
      vec_cnt++; if (ack_err !== e.err || n_ack !== 1) begin err_cnt++; $display("FAIL rderr_%0d: got err %b acks %0d expected %b 1", k, ack_err, n_ack, e.err); end
      vec_cnt++; if (ack_rdata !== e.rdata) begin err_cnt++; $display("FAIL rderr_data_%0d: got %h expected %h", k, ack_rdata, e.rdata); end
    end
  endtask

  task automatic test_timeout();
    int n; exp_t e;
    slave_cfg(0, 0, 0, 98, 0);
    @(negedge clk);
    sys_wen = 1'b1; sys_addr = 32'h4000_0040; sys_wdata = 64'h99; sys_sel = 8'hF0;
    n = cyc; e.err = 1'b1; e.rdata = 64'h0; e.chk = 1'b1; exp_q.push_back(e);
    observe(150, -1);
    vec_cnt++; if (first_ack - first_busy !== 63 || first_ack !== n + 64) begin err_cnt++; $display("FAIL to_ack_cyc: got %0d after busy (cyc %0d) expected 63 (cyc %0d)", first_ack - first_busy, first_ack, n + 64); end
    e = exp_q.pop_front();
    vec_cnt++; if (ack_err !== e.err || ack_rdata !== e.rdata) begin err_cnt++; $display("FAIL to_err_data: got %b %h expected %b %h", ack_err, ack_rdata, e.err, e.rdata); end
    vec_cnt++; if (first_bv !== n + 100) begin err_cnt++; $display("FAIL to_bvalid_cyc: got %0d expected %0d", first_bv, n + 100); end
    vec_cnt++; if (n_ack !== 1 || dbl_ack !== 1'b0) begin err_cnt++; $display("FAIL to_acks: got %0d expected 1", n_ack); end
    vec_cnt++; if (busy_low !== first_bv + 1) begin err_cnt++; $display("FAIL to_busy_low: got %0d expected %0d", busy_low, first_bv + 1); end
  endtask

  task automatic test_rst_mid();
    int k;
    slave_cfg(0, 0, 0, 0, 1000);
    @(negedge clk);
    sys_ren = 1'b1; sys_addr = 32'h8000_0200;
    k = 0;
    while (k < 10 && !axi_if.axi_rready_o) begin @(negedge clk); sys_ren = 1'b0; k++; end
    vec_cnt++; if (axi_if.axi_rready_o !== 1'b1) begin err_cnt++; $display("FAIL rstmid_reach: got rready %b expected 1", axi_if.axi_rready_o); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vec_cnt++; if ({axi_if.axi_awvalid_o, axi_if.axi_wvalid_o, axi_if.axi_arvalid_o, axi_if.axi_bready_o, axi_if.axi_rready_o, sys_ack, sys_busy} !== 7'b0) begin err_cnt++; $display("FAIL rstmid_outputs: got %b expected 0000000", {axi_if.axi_awvalid_o, axi_if.axi_wvalid_o, axi_if.axi_arvalid_o, axi_if.axi_bready_o, axi_if.axi_rready_o, sys_ack, sys_busy}); end
  endtask

  task automatic test_back_to_back();
    int n2; exp_t e;
    slave_cfg(0, 0, 0, 0, 0);
    rdata_cfg = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    sys_wen = 1'b1; sys_addr = 32'h4000_0050; sys_wdata = 64'h5; sys_sel = 8'h03;
    e.err = 1'b0; e.rdata = 64'h0; e.chk = 1'b0; exp_q.push_back(e);
    observe(30, -1);
    e = exp_q.pop_front();
    vec_cnt++; if (ack_err !== e.err || n_ack !== 1) begin err_cnt++; $display("FAIL b2b_wr: got err %b acks %0d expected %b 1", ack_err, n_ack, e.err); end
    sys_ren = 1'b1; sys_addr = 32'h8000_0300;
    n2 = cyc; e.err = 1'b0; e.rdata = 64'h0123_4567_89AB_CDEF; e.chk = 1'b1; exp_q.push_back(e);
    observe(30, 0);
    vec_cnt++; if (first_ar !== n2 + 1 || first_ack !== n2 + 3) begin err_cnt++; $display("FAIL b2b_rd_cyc: got ar %0d ack %0d expected %0d %0d", first_ar, first_ack, n2 + 1, n2 + 3); end
    e = exp_q.pop_front();
    vec_cnt++; if (ack_rdata !== e.rdata || ack_err !== e.err) begin err_cnt++; $display("FAIL b2b_rd_data: got %h %b expected %h %b", ack_rdata, ack_err, e.rdata, e.err); end
  endtask

  initial begin
    slave_cfg(0, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_write();
    test_read();
    test_w_before_aw();
    test_wen_ren();
    test_read_err();
    test_timeout();
    test_rst_mid();
    test_back_to_back();
    vec_cnt++; if (exp_q.size() !== 0) begin err_cnt++; $display("FAIL scoreboard_leftover: got %0d expected 0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
